result_packer: RTL and testbench

- Parametrised successor to the two-slot result buffer.
- Packs a stream of DATA_W-bit ALU results into MEM_WORD_SIZE-bit memory words, filling slots with an auto-incrementing slot pointer rather than an external location select.
- Presents each completed word to the memory write path with a valid/ready handshake, and applies backpressure to the ALU while a word is pending.
- Supports a flush that emits a partially filled word together with a slot mask.

---
 rtl/result_packer.sv | 106 ++++++++++
 tb/tb_result_packer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
// Packs DATA_W-bit results into MEM_WORD_SIZE-bit words via an auto-incrementing slot pointer.
// One-cycle accept latency; result_ready_o drops while a finished word waits for word_ready_i.
module result_packer #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          result_valid_i,
    input  logic [DATA_W-1:0]             result_i,
    output logic                          result_ready_o,
    input  logic                          flush_i,
    output logic                          word_valid_o,
    output logic [MEM_WORD_SIZE-1:0]      word_o,
    output logic [MEM_WORD_SIZE/DATA_W-1:0] slot_mask_o,
    input  logic                          word_ready_i,
    output logic [$clog2(MEM_WORD_SIZE/DATA_W+1)-1:0] fill_count_o
);

    localparam int SLOTS = MEM_WORD_SIZE / DATA_W;
    localparam int PTR_W = $clog2(SLOTS + 1);

    generate
        if ((MEM_WORD_SIZE % DATA_W) != 0 || SLOTS < 2) begin : g_bad_params
            $error("result_packer: MEM_WORD_SIZE must be a multiple of DATA_W with at least 2 slots");
        end
    endgenerate

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [MEM_WORD_SIZE-1:0] word_q, word_d;
    logic [SLOTS-1:0]         mask_q, mask_d;
    logic [PTR_W-1:0]         count_q, count_d;
    logic                     accept;

    assign accept = result_valid_i && (state_q == S_FILL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FILL;
            word_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            count_q <= count_d;
        end
    end

    // A flush only closes the word if it would carry at least one result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (accept && (count_q + PTR_W'(1) == PTR_W'(SLOTS))) begin
                    state_d = S_HOLD;
                end else if (flush_i && ((count_q != '0) || accept)) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (word_ready_i) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        word_d  = word_q;
        mask_d  = mask_q;
        count_d = count_q;
        if (state_q == S_HOLD) begin
            if (word_ready_i) begin
                word_d  = '0;
                mask_d  = '0;
                count_d = '0;
            end
        end else if (accept) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (count_q == PTR_W'(k)) begin
                    word_d[k*DATA_W +: DATA_W] = result_i;
                    mask_d[k]                  = 1'b1;
                end
            end
            count_d = count_q + PTR_W'(1);
        end
    end

    always_comb begin
        result_ready_o = (state_q == S_FILL);
        word_valid_o   = (state_q == S_HOLD);
    end

    assign word_o       = word_q;
    assign slot_mask_o  = mask_q;
    assign fill_count_o = count_q;

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: a default 32/64 instance and a 16/64 (four-slot) instance.
module tb_result_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_rv, a_rr, a_fl, a_wv, a_wr;
    logic [31:0] a_r;
    logic [63:0] a_w;
    logic [1:0]  a_m;
    logic [1:0]  a_c;

    logic        b_rv, b_rr, b_fl, b_wv, b_wr;
    logic [15:0] b_r;
    logic [63:0] b_w;
    logic [3:0]  b_m;
    logic [2:0]  b_c;

    int n_checks = 0;
    int n_fail   = 0;

    result_packer #(.DATA_W(32), .MEM_WORD_SIZE(64)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .result_valid_i(a_rv), .result_i(a_r), .result_ready_o(a_rr),
        .flush_i(a_fl), .word_valid_o(a_wv), .word_o(a_w),
        .slot_mask_o(a_m), .word_ready_i(a_wr), .fill_count_o(a_c)
    );

    result_packer #(.DATA_W(16), .MEM_WORD_SIZE(64)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .result_valid_i(b_rv), .result_i(b_r), .result_ready_o(b_rr),
        .flush_i(b_fl), .word_valid_o(b_wv), .word_o(b_w),
        .slot_mask_o(b_m), .word_ready_i(b_wr), .fill_count_o(b_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        a_rv = 1'b0; a_r = '0; a_fl = 1'b0; a_wr = 1'b0;
        b_rv = 1'b0; b_r = '0; b_fl = 1'b0; b_wr = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_valid", a_wv, 0);
        chk("rst_ready", a_rr, 1);
        chk("rst_word",  a_w,  0);
        chk("rst_mask",  a_m,  0);
        chk("rst_count", a_c,  0);

        // Two back-to-back accepts with downstream always ready.
        a_wr = 1'b1;
        a_rv = 1'b1; a_r = 32'hAAAA_0001;
        tick();
        chk("t1_count1", a_c, 1);
        chk("t1_mask1",  a_m, 2'b01);
        chk("t1_valid1", a_wv, 0);
        a_r = 32'hBBBB_0002;
        tick();
        a_rv = 1'b0;
        chk("t1_valid",  a_wv, 1);
        chk("t1_word",   a_w,  64'hBBBB0002_AAAA0001);
        chk("t1_mask",   a_m,  2'b11);
        chk("t1_ready",  a_rr, 0);
        chk("t1_count",  a_c,  2);
        tick();
        chk("t1_after_valid", a_wv, 0);
        chk("t1_after_ready", a_rr, 1);
        chk("t1_after_count", a_c,  0);
        chk("t1_after_word",  a_w,  0);

        // Backpressure: word held for 5 cycles while results keep coming.
        a_wr = 1'b0;
        a_rv = 1'b1; a_r = 32'h1111_1111;
        tick();
        a_r = 32'h2222_2222;
        tick();
        a_r = 32'h3333_3333;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", a_rr, 0);
            chk("bp_valid", a_wv, 1);
            chk("bp_word",  a_w,  64'h22222222_11111111);
            tick();
        end
        a_wr = 1'b1;
        tick();
        a_wr = 1'b0;
        chk("bp_released_valid", a_wv, 0);
        chk("bp_released_ready", a_rr, 1);
        tick();
        a_rv = 1'b0;
        chk("bp_next_word",  a_w, 64'h00000000_33333333);
        chk("bp_next_count", a_c, 1);
        chk("bp_next_mask",  a_m, 2'b01);
        do_reset();

        // Partial flush of a single result.
        a_rv = 1'b1; a_r = 32'h1234_5678;
        tick();
        a_rv = 1'b0; a_fl = 1'b1;
        tick();
        a_fl = 1'b0;
        chk("pf_valid", a_wv, 1);
        chk("pf_word",  a_w,  64'h00000000_12345678);
        chk("pf_mask",  a_m,  2'b01);
        chk("pf_count", a_c,  1);
        a_fl = 1'b1; a_rv = 1'b1; a_r = 32'hDEAD_BEEF;
        tick();
        a_fl = 1'b0; a_rv = 1'b0;
        chk("pf_hold_word",  a_w, 64'h00000000_12345678);
        chk("pf_hold_count", a_c, 1);
        a_wr = 1'b1;
        tick();
        a_wr = 1'b0;
        a_fl = 1'b1;
        tick();
        chk("empty_flush_valid1", a_wv, 0);
        tick();
        a_fl = 1'b0;
        chk("empty_flush_valid2", a_wv, 0);
        chk("empty_flush_count",  a_c,  0);

        // Flush and accept in the same cycle from an empty buffer.
        a_rv = 1'b1; a_r = 32'hCAFE_F00D; a_fl = 1'b1;
        tick();
        a_rv = 1'b0; a_fl = 1'b0;
        chk("fa_valid", a_wv, 1);
        chk("fa_word",  a_w,  64'h00000000_CAFEF00D);
        chk("fa_mask",  a_m,  2'b01);

        // Reset while holding a word that downstream refuses.
        a_wr = 1'b0;
        do_reset();
        chk("mr_valid", a_wv, 0);
        chk("mr_word",  a_w,  0);
        chk("mr_count", a_c,  0);
        chk("mr_mask",  a_m,  0);
        chk("mr_ready", a_rr, 1);

        // Four-slot instance: three results then flush.
        b_rv = 1'b1; b_r = 16'h0001;
        tick();
        b_r = 16'h0002;
        tick();
        b_r = 16'h0003;
        tick();
        b_rv = 1'b0;
        chk("b3_count_pre", b_c, 3);
        chk("b3_ready_pre", b_rr, 1);
        b_fl = 1'b1;
        tick();
        b_fl = 1'b0;
        chk("b3_valid", b_wv, 1);
        chk("b3_word",  b_w,  64'h0000_0003_0002_0001);
        chk("b3_mask",  b_m,  4'b0111);
        chk("b3_count", b_c,  3);
        b_wr = 1'b1;
        tick();
        b_wr = 1'b0;
        chk("b3_drained", b_wv, 0);

        // Four-slot instance: full word.
        b_rv = 1'b1;
        b_r = 16'h000A; tick();
        b_r = 16'h000B; tick();
        b_r = 16'h000C; tick();
        chk("b4_valid_pre", b_wv, 0);
        b_r = 16'h000D; tick();
        b_rv = 1'b0;
        chk("b4_valid", b_wv, 1);
        chk("b4_word",  b_w,  64'h000D_000C_000B_000A);
        chk("b4_mask",  b_m,  4'b1111);
        chk("b4_count", b_c,  4);
        chk("b4_ready", b_rr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
